// File: rtl/vc_tie_fifo_pkg.sv
// Shared NoC definitions: default flit width and sizing helpers used by the
// VC input buffer and router-level code.
package vc_tie_fifo_pkg;

  localparam int NOC_DATA_WIDTH = 32;

  function automatic int vc_bits(input int num_vc);
    return (num_vc <= 1) ? 1 : $clog2(num_vc);
  endfunction

  // Occupancy needs one bit more than the pointers so that a full queue is representable.
  function automatic int cnt_width(input int q_depth_bits);
    return q_depth_bits + 1;
  endfunction

endpackage

// File: rtl/vc_fifo_channel.sv
// One virtual-channel queue: circular storage, front/rear pointers, occupancy,
// derived flags and a sticky error bit driven by strobes from the top level.
module vc_fifo_channel
  import vc_tie_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = NOC_DATA_WIDTH,
  parameter int Q_DEPTH_BITS = 3,
  parameter int AF_SLACK     = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wen,
  input  logic                             ren,
  input  logic                             err_set,
  input  logic                             err_clr,
  input  logic [DATA_WIDTH-1:0]            write_data,
  output logic [DATA_WIDTH-1:0]            head,
  output logic [cnt_width(Q_DEPTH_BITS)-1:0] count,
  output logic                             full,
  output logic                             almost_full,
  output logic                             empty,
  output logic                             err
);

  localparam int DEPTH = 1 << Q_DEPTH_BITS;
  localparam int CW    = cnt_width(Q_DEPTH_BITS);

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [Q_DEPTH_BITS-1:0] front;
  logic [Q_DEPTH_BITS-1:0] rear;
  logic [CW-1:0]           cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      front <= '0;
      rear  <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      if (wen) rear  <= rear + 1'b1;
      if (ren) front <= front + 1'b1;
      case ({wen, ren})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (err_clr)      err <= 1'b0;
      else if (err_set) err <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wen) mem[rear] <= write_data;
  end

  assign head        = mem[front];
  assign count       = cnt;
  assign full        = (cnt == CW'(DEPTH));
  assign almost_full = (cnt >= CW'(DEPTH - AF_SLACK));
  assign empty       = (cnt == '0);

endmodule

// File: rtl/vc_tie_fifo.sv
// Virtual-channel input buffer: NUM_VC queues behind one shared write port and
// one shared read port, with ON gating, peek and same-cycle write-through bypass.
module vc_tie_fifo
  import vc_tie_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = NOC_DATA_WIDTH,
  parameter int Q_DEPTH_BITS = 3,
  parameter int NUM_VC       = 4,
  parameter int VC_BITS      = 2,
  parameter int AF_SLACK     = 2
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      ON,
  input  logic [DATA_WIDTH-1:0]                     write_data,
  input  logic                                      wrtEn,
  input  logic [VC_BITS-1:0]                        wr_vc,
  input  logic                                      rdEn,
  input  logic                                      peek,
  input  logic [VC_BITS-1:0]                        rd_vc,
  input  logic                                      err_clr,
  output logic [DATA_WIDTH-1:0]                     read_data,
  output logic                                      rd_valid,
  output logic [NUM_VC-1:0]                         full,
  output logic [NUM_VC-1:0]                         almost_full,
  output logic [NUM_VC-1:0]                         empty,
  output logic [NUM_VC-1:0]                         err,
  output logic [NUM_VC*cnt_width(Q_DEPTH_BITS)-1:0] count
);

  localparam int CW = cnt_width(Q_DEPTH_BITS);

  logic [DATA_WIDTH-1:0] head [NUM_VC];
  logic [DATA_WIDTH-1:0] head_sel;
  logic                  wr_ok, rd_ok, same, bare, wr_full;
  logic                  bypass, wacc, racc, err_wr, err_rd;
  logic [NUM_VC-1:0]     wen, ren, err_set;

  assign wr_ok = (int'(wr_vc) < NUM_VC);
  assign rd_ok = (int'(rd_vc) < NUM_VC);
  assign same  = (wr_vc == rd_vc);

  // An out-of-range read channel looks empty, which forces rd_valid low.
  always_comb begin
    wr_full  = 1'b0;
    bare     = 1'b1;
    head_sel = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (wr_vc == VC_BITS'(v)) wr_full = full[v];
      if (rd_vc == VC_BITS'(v)) begin
        bare     = empty[v];
        head_sel = head[v];
      end
    end
  end

  // Reset gating keeps the read port quiet while reset is held.
  assign bypass = reset & ON & wrtEn & (rdEn | peek) & same & bare & wr_ok & rd_ok;
  assign wacc   = ON & wrtEn & wr_ok & (~wr_full | (same & rdEn)) & ~(bypass & rdEn);
  assign racc   = ON & rdEn & rd_ok & ~bare & ~bypass;
  // A consumed bypass flit is a successful transfer, not a refused write.
  assign err_wr = ON & wrtEn & wr_ok & ~wacc & ~(bypass & rdEn);
  assign err_rd = ON & rdEn & rd_ok & bare & ~bypass;

  assign rd_valid  = reset & (bypass | ((rdEn | peek) & ~bare));
  assign read_data = bypass ? write_data : (rd_valid ? head_sel : '0);

  always_comb begin
    wen     = '0;
    ren     = '0;
    err_set = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      wen[v]     = wacc & (wr_vc == VC_BITS'(v));
      ren[v]     = racc & (rd_vc == VC_BITS'(v));
      err_set[v] = (err_wr & (wr_vc == VC_BITS'(v))) | (err_rd & (rd_vc == VC_BITS'(v)));
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_fifo_channel #(
      .DATA_WIDTH  (DATA_WIDTH),
      .Q_DEPTH_BITS(Q_DEPTH_BITS),
      .AF_SLACK    (AF_SLACK)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .wen        (wen[v]),
      .ren        (ren[v]),
      .err_set    (err_set[v]),
      .err_clr    (ON & err_clr),
      .write_data (write_data),
      .head       (head[v]),
      .count      (count[v*CW +: CW]),
      .full       (full[v]),
      .almost_full(almost_full[v]),
      .empty      (empty[v]),
      .err        (err[v])
    );
  end

endmodule

// File: tb/tb_vc_tie_fifo.sv
// Bench for vc_tie_fifo: directed scenarios plus random traffic, each cycle
// compared against per-channel queue model.
module tb_vc_tie_fifo;

  localparam int NV = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        on;
  logic [31:0] wdata;
  logic        wrt_en;
  logic [1:0]  wr_vc;
  logic        rd_en;
  logic        peek;
  logic [1:0]  rd_vc;
  logic        err_clr;
  logic [31:0] read_data;
  logic        rd_valid;
  logic [3:0]  full, almost_full, empty, err;
  logic [15:0] count;

  logic [31:0] exp_q [NV][$];
  logic [3:0]  exp_err;
  int          total = 0;
  int          bad = 0;

  vc_tie_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .ON         (on),
    .write_data (wdata),
    .wrtEn      (wrt_en),
    .wr_vc      (wr_vc),
    .rdEn       (rd_en),
    .peek       (peek),
    .rd_vc      (rd_vc),
    .err_clr    (err_clr),
    .read_data  (read_data),
    .rd_valid   (rd_valid),
    .full       (full),
    .almost_full(almost_full),
    .empty      (empty),
    .err        (err),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_flags();
    logic [3:0]  ef, ea, ee;
    logic [15:0] ec;
    for (int v = 0; v < NV; v++) begin
      int n;
      n = exp_q[v].size();
      ef[v] = (n == DEPTH);
      ea[v] = (n >= DEPTH - 2);
      ee[v] = (n == 0);
      ec[v*4 +: 4] = 4'(n);
    end
    check("full", full, ef);
    check("almost_full", almost_full, ea);
    check("empty", empty, ee);
    check("count", count, ec);
    check("err", err, exp_err);
  endtask

  // Called just after a falling edge with inputs set; checks, then advances one clock.
  task automatic cycle();
    logic bare, same, byp, exp_rv, wacc, racc, ewr, erd;
    logic [31:0] exp_rd;
    bare   = (exp_q[rd_vc].size() == 0);
    same   = (wr_vc == rd_vc);
    byp    = reset && on && wrt_en && (rd_en || peek) && same && bare;
    exp_rv = reset && (byp || ((rd_en || peek) && !bare));
    exp_rd = byp ? wdata : (exp_rv ? exp_q[rd_vc][0] : 32'h0);
    wacc   = on && wrt_en && ((exp_q[wr_vc].size() < DEPTH) || (same && rd_en)) && !(byp && rd_en);
    racc   = on && rd_en && !bare && !byp;
    ewr    = on && wrt_en && !wacc && !(byp && rd_en);
    erd    = on && rd_en && bare && !byp;
    #1;
    check("rd_valid", rd_valid, exp_rv);
    check("read_data", read_data, exp_rd);
    check_flags();
    @(posedge clk);
    if (reset && on) begin
      if (racc) void'(exp_q[rd_vc].pop_front());
      if (wacc) exp_q[wr_vc].push_back(wdata);
      if (err_clr) exp_err = '0;
      else begin
        if (ewr) exp_err[wr_vc] = 1'b1;
        if (erd) exp_err[rd_vc] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic [1:0] wv, input logic [31:0] d,
                       input logic r, input logic p, input logic [1:0] rv);
    wrt_en = w; wr_vc = wv; wdata = d; rd_en = r; peek = p; rd_vc = rv;
    cycle();
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) exp_q[v].delete();
    exp_err = '0;
  endtask

  initial begin
    reset = 1'b0; on = 1'b1; err_clr = 1'b0;
    wrt_en = 1'b0; wr_vc = '0; wdata = '0; rd_en = 1'b0; peek = 1'b0; rd_vc = '0;
    model_reset();
    @(negedge clk);
    drive(1'b1, 2'd0, 32'h11, 1'b1, 1'b0, 2'd0);
    reset = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 2'd0);

    // Fill VC1 to full, then one more for an overflow error.
    for (int i = 0; i < 9; i++) drive(1'b1, 2'd1, 32'hA0 + 32'(i), 1'b0, 1'b0, 2'd1);
    check("af1_full1", {almost_full[1], full[1]}, 2'b11);
    drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 2'd0);
    err_clr = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 2'd0);
    err_clr = 1'b0;

    // Write into a full channel while reading it, then drain in order.
    drive(1'b1, 2'd1, 32'hB0, 1'b1, 1'b0, 2'd1);
    for (int i = 0; i < 8; i++) drive(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 2'd1);

    // Bypass on an empty channel: consumed, then peek-only enqueues.
    drive(1'b1, 2'd2, 32'h55, 1'b1, 1'b0, 2'd2);
    drive(1'b1, 2'd2, 32'h66, 1'b0, 1'b1, 2'd2);
    drive(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 2'd2);

    // Independent channels in the same cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, 32'hC0 + 32'(i), 1'b0, 1'b0, 2'd0);
      drive(1'b1, 2'd3, 32'hD0 + 32'(i), 1'b0, 1'b0, 2'd0);
    end
    drive(1'b1, 2'd0, 32'hC3, 1'b1, 1'b0, 2'd3);
    check("count0_count3", {count[3:0], count[15:12]}, {4'd4, 4'd2});

    // Frozen for three cycles with traffic requested.
    on = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, 2'd0, 32'hEE, 1'b1, 1'b0, 2'(i));
    on = 1'b1;

    // Long same-channel stream wraps the pointers several times.
    drive(1'b1, 2'd1, 32'h100, 1'b0, 1'b0, 2'd1);
    for (int i = 1; i < 20; i++) drive(1'b1, 2'd1, 32'h100 + 32'(i), 1'b1, 1'b0, 2'd1);
    drive(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 2'd1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      on      = ($urandom_range(0, 9) != 0);
      err_clr = ($urandom_range(0, 19) == 0);
      drive($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)));
    end
    on = 1'b1; err_clr = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 2'd0);
    err_clr = 1'b0;
    for (int i = 0; i < 8; i++) drive(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 2'd0);

    // Reset mid-burst with VC0 holding 5 flits and a read pending.
    for (int i = 0; i < 5; i++) drive(1'b1, 2'd0, 32'hF0 + 32'(i), 1'b0, 1'b0, 2'd0);
    wrt_en = 1'b1; wdata = 32'hF5; rd_en = 1'b1; rd_vc = 2'd0; wr_vc = 2'd1;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_read_data", read_data, 32'h0);
    check("rst_empty", empty, 4'hF);
    check("rst_count", count, 16'h0);
    check_flags();
    @(negedge clk);
    drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 2'd0);
    reset = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 2'd0);
    drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 2'd0);
    check("err0_after_empty_read", err[0], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vc_tie_fifo.md
# vc_tie_fifo

Multi-channel successor to the single-queue router FIFO. It holds NUM_VC independent circular queues behind one shared write port and one shared read port, for use as the virtual-channel input buffer of a NoC router port. Each channel has its own pointers, occupancy count, full, almost-full and empty flags, and a sticky error flag. The ON gate, peek and same-cycle write-through bypass behaviour of the existing FIFO are kept, and the read side adds an explicit valid.

## Interface
- DATA_WIDTH, 32, flit width in bits
- Q_DEPTH_BITS, 3, log2 of per-channel depth; DEPTH = 2**Q_DEPTH_BITS
- NUM_VC, 4, number of channels (>=2)
- VC_BITS, 2, width of channel selects; must satisfy 2**VC_BITS >= NUM_VC
- AF_SLACK, 2, almost_full asserts when count >= DEPTH-AF_SLACK (0 < AF_SLACK < DEPTH)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  one clock; reset is asynchronous and active-low
- ON  in  1  global enable; 0 freezes all state
- write_data  in  DATA_WIDTH  flit to enqueue
- wrtEn  in  1  write request
- wr_vc  in  VC_BITS  target channel of write
- rdEn  in  1  dequeue request
- peek  in  1  look without dequeue
- rd_vc  in  VC_BITS  source channel of read/peek
- err_clr  in  1  clears all sticky error bits
- read_data  out  DATA_WIDTH  head flit of rd_vc (or bypassed write_data); 0 when rd_valid=0
- rd_valid  out  1  read_data is meaningful
- full  out  NUM_VC  count==DEPTH per channel
- almost_full  out  NUM_VC  count>=DEPTH-AF_SLACK per channel
- empty  out  NUM_VC  count==0 per channel
- err  out  NUM_VC  sticky overflow/underflow per channel
- count  out  NUM_VC*(Q_DEPTH_BITS+1)  occupancy, channel v at bits [v*(Q_DEPTH_BITS+1) +: Q_DEPTH_BITS+1]

## Operation
- Define same = (wr_vc==rd_vc) and bare = empty[rd_vc].
- bypass = ON & wrtEn & (rdEn|peek) & same & bare.
  - read_data = write_data and rd_valid = 1.
  - With rdEn, the flit is consumed and no state changes.
  - With peek only, the flit is enqueued normally.
- Otherwise rd_valid = (rdEn|peek) & ~bare, and read_data = queue[rd_vc][front[rd_vc]] (first-word fall-through).
- Write acceptance: wacc = ON & wrtEn & (~full[wr_vc] | (same & rdEn)) & ~(bypass & rdEn).
  - A write to a full channel is accepted when the same channel is read in the same cycle.
- Read acceptance: racc = ON & rdEn & ~bare & ~bypass.
- Accepted write: store at rear, then rear++.
- Accepted read: front++.
- Pointers wrap naturally at DEPTH (power of two).
- Per-channel count update:
  - +1 for write only
  - −1 for read only
  - unchanged for both or neither
- Different channels on write and read in the same cycle are fully independent.
- Error flags (set only when ON=1):
  - err[wr_vc] sets on wrtEn & ~wacc.
  - err[rd_vc] sets on rdEn & bare & ~bypass.
  - err_clr has priority over set in the same cycle.
- ON=0: no pointer, count, memory or err update.
  - Flags still reflect state.
  - Bypass is disabled.
  - rd_valid follows the non-bypass rule.
- wr_vc or rd_vc >= NUM_VC: that access is ignored and raises no error. rd_valid=0.

## Timing
- Writes, reads and flag updates take effect on the rising clk edge. Flags are registered or derived from registered count, with 1-cycle visibility after the edge.
- read_data, rd_valid and bypass are combinational from inputs and state, with zero-cycle latency.
- Reset asserted, at any time including mid-transfer:
  - Pointers, counts and err clear immediately.
  - empty = all 1; full, almost_full and err = 0; count = 0.
  - rd_valid = 0 and read_data = 0.
  - Memory contents are not reset.
- The first accepted operation is on the first rising edge after reset deasserts.

## Structure
- A shared NoC package/header holds the DATA_WIDTH default, the VC_BITS clog2 helper and the count-field width macro. Router-level code uses it too.
- Sub-module vc_fifo_channel contains one queue: storage, front/rear/count, flags, and the err bit with per-channel wen/ren/clr strobes. It is instantiated NUM_VC times in a generate loop.
- The top level handles decode, bypass, acceptance logic and the output mux.

## Test plan
- Reset, then write 0xA0..0xA7 to VC1 (DEPTH=8) → almost_full[1] after the 6th, full[1] after the 8th. A 9th write sets err[1] and count stays 8.
- VC1 full; write 0xB0 and read VC1 in the same cycle → read_data=0xA0, count stays 8, 0xB0 read last, no err.
- VC2 empty, wrtEn+rdEn with write_data=0x55, wr_vc=rd_vc=2 → read_data=0x55, rd_valid=1, empty[2] stays 1, count 0.
- Write VC0 and read VC3 in the same cycle, each preloaded with 3 flits → count0=4, count3=2, other channels unchanged.
- ON=0 for 3 cycles with wrtEn/rdEn active → no count, pointer or err change. Resume at ON=1 → FIFO order preserved across 20 wrap-around flits.
- Assert reset mid-burst with VC0 holding 5 flits → all outputs at reset values with no clock edge. Read after release gives rd_valid=0 and err[0]=1.
